// File: rtl/alu_issue.sv
// Request/response wrapper around an external combinational ALU: registers operands,
// waits SETTLE_CYCLES for the ALU to settle, captures result and flags, keeps sticky flags.
module alu_issue #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [5:0]  alu_ctrl,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_result,
  input  logic        alu_of,
  input  logic        alu_je,
  input  logic        alu_ja,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_of,
  output logic        rsp_je,
  output logic        rsp_ja,
  output logic        rsp_err,
  input  logic        flag_clr,
  output logic        flag_of,
  output logic        flag_je,
  output logic        flag_ja
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] OP_MAX   = 6'b010000;
  localparam logic [5:0] OP_DIV   = 6'b001010;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  alu_ctrl_q;
  logic [31:0] alu_in1_q;
  logic [31:0] alu_in2_q;
  logic [31:0] rsp_result_q;
  logic        rsp_of_q;
  logic        rsp_je_q;
  logic        rsp_ja_q;
  logic        rsp_err_q;
  logic [2:0]  flag_q;
  logic [2:0]  flag_d;

  logic req_err;
  logic capture;

  assign req_err = (req_op > OP_MAX) || ((req_op == OP_DIV) && (req_b == '0));
  assign capture = (state_q == EXEC) && (cnt_q == '0);

  // A capture overwrites the sticky flags when a clear arrives on the same edge.
  always_comb begin
    flag_d = flag_q;
    if (capture) begin
      flag_d = (flag_clr ? 3'b000 : flag_q) | {alu_of, alu_je, alu_ja};
    end else if (flag_clr) begin
      flag_d = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_ctrl_q   <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      rsp_result_q <= '0;
      rsp_of_q     <= 1'b0;
      rsp_je_q     <= 1'b0;
      rsp_ja_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      flag_q       <= '0;
    end else begin
      flag_q <= flag_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              rsp_result_q <= '0;
              rsp_of_q     <= 1'b0;
              rsp_je_q     <= 1'b0;
              rsp_ja_q     <= 1'b0;
              rsp_err_q    <= 1'b1;
              state_q      <= RESP;
            end else begin
              alu_ctrl_q <= req_op;
              alu_in1_q  <= req_a;
              alu_in2_q  <= req_b;
              cnt_q      <= CNT_LOAD;
              state_q    <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_result_q <= alu_result;
            rsp_of_q     <= alu_of;
            rsp_je_q     <= alu_je;
            rsp_ja_q     <= alu_ja;
            rsp_err_q    <= 1'b0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign rsp_result = rsp_result_q;
  assign rsp_of     = rsp_of_q;
  assign rsp_je     = rsp_je_q;
  assign rsp_ja     = rsp_ja_q;
  assign rsp_err    = rsp_err_q;
  assign flag_of    = flag_q[2];
  assign flag_je    = flag_q[1];
  assign flag_ja    = flag_q[0];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: default-settle instance for the main traffic,
// a SETTLE_CYCLES=4 instance for latency and reset-in-EXEC.
module tb_alu_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, flag_clr;
  logic [5:0]  req_op, alu_ctrl;
  logic [31:0] req_a, req_b, alu_in1, alu_in2, alu_result, rsp_result;
  logic        alu_of, alu_je, alu_ja, rsp_of, rsp_je, rsp_ja, rsp_err;
  logic        flag_of, flag_je, flag_ja;

  // SETTLE_CYCLES=4 instance signals
  logic        d4_rst, d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready, d4_flag_clr;
  logic [5:0]  d4_req_op, d4_alu_ctrl;
  logic [31:0] d4_req_a, d4_req_b, d4_alu_in1, d4_alu_in2, d4_alu_result, d4_rsp_result;
  logic        d4_alu_of, d4_alu_je, d4_alu_ja, d4_rsp_of, d4_rsp_je, d4_rsp_ja, d4_rsp_err;
  logic        d4_flag_of, d4_flag_je, d4_flag_ja;

  int checks = 0;
  int failures = 0;

  // Reference ALU: returns {of, je, ja, result}
  function automatic logic [34:0] alu_fn(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic        of;
    of = 1'b0;
    case (op)
      6'd0:  r = a & b;
      6'd1:  begin r = a + b; of = (a[31] == b[31]) && (r[31] != a[31]); end
      6'd2:  begin r = a - b; of = (a[31] != b[31]) && (r[31] != a[31]); end
      6'd4:  r = a | b;
      6'd10: r = (b == 0) ? 32'd0 : a / b;
      6'd15: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a ^ b;
    endcase
    return {of, a == b, $signed(a) > $signed(b), r};
  endfunction

  assign {alu_of, alu_je, alu_ja, alu_result} = alu_fn(alu_ctrl, alu_in1, alu_in2);
  assign {d4_alu_of, d4_alu_je, d4_alu_ja, d4_alu_result} = alu_fn(d4_alu_ctrl, d4_alu_in1, d4_alu_in2);

  alu_issue u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_of(alu_of), .alu_je(alu_je), .alu_ja(alu_ja),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_of(rsp_of), .rsp_je(rsp_je), .rsp_ja(rsp_ja), .rsp_err(rsp_err),
    .flag_clr(flag_clr), .flag_of(flag_of), .flag_je(flag_je), .flag_ja(flag_ja)
  );

  alu_issue #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(d4_rst), .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req_op(d4_req_op), .req_a(d4_req_a), .req_b(d4_req_b),
    .alu_ctrl(d4_alu_ctrl), .alu_in1(d4_alu_in1), .alu_in2(d4_alu_in2),
    .alu_result(d4_alu_result), .alu_of(d4_alu_of), .alu_je(d4_alu_je), .alu_ja(d4_alu_ja),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_result(d4_rsp_result),
    .rsp_of(d4_rsp_of), .rsp_je(d4_rsp_je), .rsp_ja(d4_rsp_ja), .rsp_err(d4_rsp_err),
    .flag_clr(d4_flag_clr), .flag_of(d4_flag_of), .flag_je(d4_flag_je), .flag_ja(d4_flag_ja)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        of, je, ja, err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  exp_flag = 3'b000;
  logic [5:0]  exp_ctrl = '0;
  logic [31:0] exp_in1 = '0, exp_in2 = '0;

  // Issue one request, check the response through the scoreboard, hold it for `hold` cycles.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit clr_cap);
    exp_t        e, g;
    logic [34:0] m;
    int          n, lat;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 6'($urandom); req_a = $urandom; req_b = $urandom;
    e.err = (op > 6'b010000) || (op == 6'd10 && b == 0);
    m = alu_fn(op, a, b);
    if (e.err) begin
      e.res = '0; {e.of, e.je, e.ja} = 3'b000; e.lat = 1;
    end else begin
      e.res = m[31:0]; {e.of, e.je, e.ja} = m[34:32]; e.lat = 2;
      exp_flag = (clr_cap ? 3'b000 : exp_flag) | m[34:32];
      exp_ctrl = op; exp_in1 = a; exp_in2 = b;
    end
    sb.push_back(e);
    if (clr_cap) flag_clr = 1'b1;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    flag_clr = 1'b0;
    g = sb.pop_front();
    check("latency", 32'(lat), 32'(g.lat));
    check("rsp_result", rsp_result, g.res);
    check("rsp_flags", 32'({rsp_of, rsp_je, rsp_ja}), 32'({g.of, g.je, g.ja}));
    check("rsp_err", 32'(rsp_err), 32'(g.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'({rsp_valid, req_ready}), 32'b10);
      check("hold_result", rsp_result, g.res);
      check("hold_bits", 32'({rsp_of, rsp_je, rsp_ja, rsp_err}), 32'({g.of, g.je, g.ja, g.err}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_hs", 32'({rsp_valid, req_ready}), 32'b01);
    check("sticky", 32'({flag_of, flag_je, flag_ja}), 32'(exp_flag));
    check("alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl));
    check("alu_ins", alu_in1 ^ alu_in2, exp_in1 ^ exp_in2);
    check("alu_in1", alu_in1, exp_in1);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [5:0] ops [8];
    ops = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd10, 6'd15, 6'd16, 6'd17};
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; flag_clr = 1'b0;
    d4_rst = 1'b1; d4_req_valid = 1'b0; d4_req_op = '0; d4_req_a = '0; d4_req_b = '0;
    d4_rsp_ready = 1'b1; d4_flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({rsp_valid, rsp_of, rsp_je, rsp_ja, rsp_err, flag_of, flag_je, flag_ja}), 32'd0);
    check("rst_data", rsp_result | alu_in1 | alu_in2 | 32'(alu_ctrl), 32'd0);
    rst = 1'b0; d4_rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    issue(6'd1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);   // add overflow
    issue(6'd15, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);  // signed less-than
    issue(6'd10, 32'd10, 32'd0, 0, 1'b0);                 // divide by zero
    issue(6'h11, 32'd3, 32'd4, 0, 1'b0);                  // first illegal op
    issue(6'h3F, 32'd3, 32'd4, 0, 1'b0);
    issue(6'h10, 32'h1234_5678, 32'h0F0F_0F0F, 0, 1'b0);  // highest legal op
    issue(6'd4, 32'hA000_0001, 32'h0500_0010, 5, 1'b0);   // backpressure
    issue(6'd10, 32'd100, 32'd7, 0, 1'b0);
    issue(6'd1, 32'd5, 32'd5, 0, 1'b1);                   // clear vs capture
    check("clr_cap", 32'({flag_of, flag_je}), 32'b01);

    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    exp_flag = 3'b000;
    check("flag_clr", 32'({flag_of, flag_je, flag_ja}), 32'd0);

    for (int k = 0; k < 10; k++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(ops[$urandom_range(0, 7)], $urandom, rb, $urandom_range(0, 2), 1'b0);
    end

    // reset while in RESP, with a handshake and flag_clr on the same edge
    req_valid = 1'b1; req_op = 6'd2; req_a = 32'd9; req_b = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_rsp", 32'(rsp_valid), 32'd1);
    rst = 1'b1; rsp_ready = 1'b1; flag_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b0; flag_clr = 1'b0;
    exp_flag = 3'b000; exp_ctrl = '0; exp_in1 = '0; exp_in2 = '0;
    check("rst_resp", 32'({rsp_valid, req_ready, flag_je}), 32'b010);
    check("rst_resp_alu", 32'(alu_ctrl) | alu_in1 | rsp_result, 32'd0);

    // SETTLE_CYCLES=4: latency, then reset in the second EXEC cycle
    d4_req_valid = 1'b1; d4_req_op = 6'd2; d4_req_a = 32'd50; d4_req_b = 32'd8;
    @(negedge clk);
    d4_req_valid = 1'b0;
    lat = 1;
    while (!d4_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("d4_latency", 32'(lat), 32'd5);
    check("d4_result", d4_rsp_result, 32'd42);
    @(negedge clk);
    d4_req_valid = 1'b1; d4_req_op = 6'd1; d4_req_a = 32'd3; d4_req_b = 32'd4;
    @(negedge clk);
    d4_req_valid = 1'b0;
    check("d4_exec_busy", 32'(d4_req_ready), 32'd0);
    @(negedge clk);
    d4_rst = 1'b1;
    @(negedge clk);
    d4_rst = 1'b0;
    check("d4_rst_outs", 32'({d4_rsp_valid, d4_rsp_of, d4_rsp_je, d4_rsp_ja, d4_rsp_err,
                              d4_flag_of, d4_flag_je, d4_flag_ja}), 32'd0);
    check("d4_rst_data", d4_rsp_result | d4_alu_in1 | d4_alu_in2 | 32'(d4_alu_ctrl), 32'd0);
    check("d4_rst_ready", 32'(d4_req_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d4_rsp_valid) seen = 1'b1;
    end
    check("d4_no_rsp", 32'(seen), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
